// File: rtl/pio_pkg.sv
// Shared constants for the parallel-input edge-capture block: edge
// selection codes, register map addresses and the edge-match helper.
package pio_pkg;

  // Edge selection codes for the EDGE_TYPE parameter
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  // Width of the per-bit glitch-filter counter (covers counts 0..255)
  localparam int FILT_CNT_W = 8;

  // Returns 1 when the transition prev -> cur matches the selected edge kind
  function automatic logic edge_match(input int edge_type, input logic cur, input logic prev);
    logic hit;
    case (edge_type)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_ANY:  hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_bit_filter.sv
// One input bit: synchroniser chain, optional glitch filter and edge detect.
// The edge strobe is taken from the value the filtered flop is about to load
// against its current content, so a capture lands on the same clock edge as
// the filtered bit changes.
module pio_bit_filter
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_TYPE     = 0,
  parameter int FILTER_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic filt_bit,
  output logic edge_hit
);

  localparam logic [FILT_CNT_W-1:0] FILT_N = FILT_CNT_W'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   filt_r;
  logic [FILT_CNT_W-1:0]  cnt_r;
  logic                   sync_s;
  logic                   filt_next_s;
  logic [FILT_CNT_W-1:0]  cnt_next_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain for the asynchronous input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], in_bit};
    end
  end

  // Filter decision: adopt the synchronised value once it has disagreed for FILT_N cycles
  always_comb begin
    filt_next_s = filt_r;
    cnt_next_s  = {FILT_CNT_W{1'b0}};
    if (sync_s != filt_r) begin
      if (cnt_r == FILT_N) begin
        filt_next_s = sync_s;
        cnt_next_s  = {FILT_CNT_W{1'b0}};
      end else begin
        cnt_next_s  = cnt_r + {{(FILT_CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_next_s = {FILT_CNT_W{1'b0}};
    end
  end

  // Filtered value and stability counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_r <= 1'b0;
      cnt_r  <= {FILT_CNT_W{1'b0}};
    end else begin
      filt_r <= filt_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

  assign filt_bit = filt_r;
  assign edge_hit = edge_match(EDGE_TYPE, filt_next_s, filt_r);

endmodule

// File: rtl/pio_edge_irq_in.sv
// Parallel input port with per-bit edge capture, interrupt mask and a
// registered read path. irq is decoded purely from the capture and mask flops.
module pio_edge_irq_in
  import pio_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_TYPE     = 0,
  parameter int FILTER_CYCLES = 0,
  parameter int BIT_CLEAR     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filt_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] cap_next_s;
  logic [WIDTH-1:0] cap_r;
  logic [WIDTH-1:0] mask_r;
  logic [31:0]      rd_next_s;
  logic [31:0]      rd_r;
  logic             wr_s;
  logic             unused_wdata_s;

  // Upper write-data bits beyond WIDTH carry no meaning
  assign unused_wdata_s = ^writedata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_bit_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .EDGE_TYPE    (EDGE_TYPE),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bit  (in_port[gi]),
        .filt_bit(filt_s[gi]),
        .edge_hit(edge_s[gi])
      );
    end
  endgenerate

  assign wr_s = chipselect & ~write_n;

  // Clear vector from a write to the capture register; new edges override it
  always_comb begin
    clr_s = {WIDTH{1'b0}};
    if (wr_s && (address == ADDR_CAP)) begin
      if (BIT_CLEAR != 0) begin
        clr_s = writedata[WIDTH-1:0];
      end else begin
        clr_s = {WIDTH{1'b1}};
      end
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    cap_next_s = (cap_r & ~clr_s) | edge_s;
  end

  // Capture and mask registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_r  <= {WIDTH{1'b0}};
      mask_r <= {WIDTH{1'b0}};
    end else begin
      cap_r <= cap_next_s;
      if (wr_s && (address == ADDR_MASK)) begin
        mask_r <= writedata[WIDTH-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Read multiplexer, zero-extended to the bus width
  always_comb begin
    rd_next_s = 32'd0;
    case (address)
      ADDR_DATA: rd_next_s[WIDTH-1:0] = filt_s;
      ADDR_RSVD: rd_next_s = 32'd0;
      ADDR_MASK: rd_next_s[WIDTH-1:0] = mask_r;
      ADDR_CAP:  rd_next_s[WIDTH-1:0] = cap_r;
      default:   rd_next_s = 32'd0;
    endcase
  end

  // Read data register, refreshed every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_r <= 32'd0;
    end else begin
      rd_r <= rd_next_s;
    end
  end

  assign readdata = rd_r;
  assign irq      = |(cap_r & mask_r);

endmodule

// File: tb/tb_pio_edge_irq_in.sv
// Self-checking bench for pio_edge_irq_in: directed scenarios on several
// parameterisations plus a randomized run against a delay-line model.
module tb_pio_edge_irq_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic [31:0] in2;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int n_tests;
  int n_fail;

  // Defaults: rising edge, no filter, per-bit clear
  pio_edge_irq_in #(.WIDTH(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

  // Glitch filter of 4 cycles
  pio_edge_irq_in #(.WIDTH(8), .FILTER_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

  // Any edge, full 32-bit width
  pio_edge_irq_in #(.WIDTH(32), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

  // Clear-all on any capture write, shares inputs with dut0
  pio_edge_irq_in #(.WIDTH(8), .BIT_CLEAR(0)) dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0), .readdata(rd3), .irq(irq3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    in0        = 8'h00;
    in1        = 8'h00;
    in2        = 32'h0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset_n = 1'b0;
    in0 = 8'hFF;
    in2 = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rd0: got %h exp %h", rd0, 32'h0); end
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq0: got %b exp 0", irq0); end
    n_tests++; if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2: got %h exp %h", rd2, 32'h0); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    address = 2'd3;
    in0 = 8'h01;
    tick(); tick(); tick();
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL basic_cap_early: got %h exp %h", rd0, 32'h0); end
    tick();
    n_tests++; if (rd0 !== 32'h1) begin n_fail++; $display("FAIL basic_cap: got %h exp %h", rd0, 32'h1); end
    address = 2'd0;
    tick();
    n_tests++; if (rd0 !== 32'h1) begin n_fail++; $display("FAIL basic_data: got %h exp %h", rd0, 32'h1); end
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL basic_irq: got %b exp 0", irq0); end
    address = 2'd1;
    tick();
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL basic_rsvd: got %h exp %h", rd0, 32'h0); end
  endtask

  task automatic test_irq();
    do_reset();
    bus_write(2'd2, 32'h1);
    address = 2'd2;
    tick();
    n_tests++; if (rd0 !== 32'h1) begin n_fail++; $display("FAIL irq_mask_read: got %h exp %h", rd0, 32'h1); end
    in0 = 8'h01;
    tick();
    in0 = 8'h00;
    tick(); tick(); tick();
    n_tests++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b exp 1", irq0); end
    bus_write(2'd3, 32'h1);
    tick();
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b exp 0", irq0); end
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL irq_cap_cleared: got %h exp %h", rd0, 32'h0); end
  endtask

  task automatic test_set_wins();
    do_reset();
    address = 2'd3;
    in0 = 8'h05;
    tick(); tick(); tick(); tick();
    in0 = 8'h04;
    tick(); tick(); tick(); tick();
    n_tests++; if (rd0 !== 32'h5) begin n_fail++; $display("FAIL setwin_pre: got %h exp %h", rd0, 32'h5); end
    in0 = 8'h05;
    tick(); tick();
    bus_write(2'd3, 32'h1);
    tick();
    n_tests++; if (rd0 !== 32'h5) begin n_fail++; $display("FAIL setwin_bitclr: got %h exp %h", rd0, 32'h5); end
    n_tests++; if (rd3 !== 32'h1) begin n_fail++; $display("FAIL setwin_allclr: got %h exp %h", rd3, 32'h1); end
    bus_write(2'd3, 32'h4);
    tick();
    n_tests++; if (rd0 !== 32'h1) begin n_fail++; $display("FAIL setwin_clr4: got %h exp %h", rd0, 32'h1); end
    n_tests++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL setwin_allclr2: got %h exp %h", rd3, 32'h0); end
  endtask

  task automatic test_filter();
    do_reset();
    address = 2'd0;
    in1 = 8'h04;
    tick(); tick(); tick();
    in1 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++; if (rd1[2] !== 1'b0) begin n_fail++; $display("FAIL filt_glitch_data: cycle %0d got %b exp 0", i, rd1[2]); end
    end
    address = 2'd3;
    tick();
    n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL filt_glitch_cap: got %h exp %h", rd1, 32'h0); end
    in1 = 8'h04;
    for (int e = 1; e <= 8; e++) begin
      if (e == 7) in1 = 8'h00;
      tick();
      if (e == 7) begin
        n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL filt_cap_early: got %h exp %h", rd1, 32'h0); end
      end
      if (e == 8) begin
        n_tests++; if (rd1 !== 32'h4) begin n_fail++; $display("FAIL filt_cap: got %h exp %h", rd1, 32'h4); end
      end
    end
  endtask

  task automatic test_any_edge();
    do_reset();
    address = 2'd3;
    in2 = 32'h8000_0000;
    tick(); tick(); tick(); tick();
    n_tests++; if (rd2 !== 32'h8000_0000) begin n_fail++; $display("FAIL any_rise_cap: got %h exp %h", rd2, 32'h8000_0000); end
    address = 2'd0;
    tick();
    n_tests++; if (rd2 !== 32'h8000_0000) begin n_fail++; $display("FAIL any_data_hi: got %h exp %h", rd2, 32'h8000_0000); end
    bus_write(2'd3, 32'h8000_0000);
    tick();
    n_tests++; if (rd2 !== 32'h0) begin n_fail++; $display("FAIL any_cleared: got %h exp %h", rd2, 32'h0); end
    in2 = 32'h0;
    tick(); tick(); tick(); tick();
    n_tests++; if (rd2 !== 32'h8000_0000) begin n_fail++; $display("FAIL any_fall_cap: got %h exp %h", rd2, 32'h8000_0000); end
    address = 2'd0;
    tick();
    n_tests++; if (rd2 !== 32'h0) begin n_fail++; $display("FAIL any_data_lo: got %h exp %h", rd2, 32'h0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus_write(2'd2, 32'hFF);
    in0 = 8'h03;
    in1 = 8'h04;
    address = 2'd3;
    tick(); tick(); tick(); tick();
    n_tests++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_irq: got %b exp 1", irq0); end
    n_tests++; if (rd0 !== 32'h3) begin n_fail++; $display("FAIL arst_pre_cap: got %h exp %h", rd0, 32'h3); end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL arst_rd0: got %h exp %h", rd0, 32'h0); end
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL arst_irq0: got %b exp 0", irq0); end
    tick(); tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) begin
        n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL arst_rel_early: got %h exp %h", rd0, 32'h0); end
      end
      if (e == 4) begin
        n_tests++; if (rd0 !== 32'h3) begin n_fail++; $display("FAIL arst_rel_cap: got %h exp %h", rd0, 32'h3); end
        n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL arst_mask_cleared: got %b exp 0", irq0); end
      end
      if (e == 7) begin
        n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL arst_filt_early: got %h exp %h", rd1, 32'h0); end
      end
      if (e == 8) begin
        n_tests++; if (rd1 !== 32'h4) begin n_fail++; $display("FAIL arst_filt_cap: got %h exp %h", rd1, 32'h4); end
      end
    end
  endtask

  // Reference: filtered data is the input sampled two edges earlier; captures
  // are rising transitions of that delayed stream; reads show pre-edge state.
  task automatic test_random();
    logic [7:0]  p1, p2, p3, cap_m, mask_m, rise, clr;
    logic [31:0] exp_rd;
    logic        wr, exp_irq;
    do_reset();
    p1 = 8'h0; p2 = 8'h0; p3 = 8'h0; cap_m = 8'h0; mask_m = 8'h0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) in0 = 8'($urandom);
      address    = 2'($urandom);
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      writedata  = $urandom;
      wr = chipselect && !write_n;
      case (address)
        2'd0:    exp_rd = {24'h0, p3};
        2'd2:    exp_rd = {24'h0, mask_m};
        2'd3:    exp_rd = {24'h0, cap_m};
        default: exp_rd = 32'h0;
      endcase
      rise  = p2 & ~p3;
      clr   = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
      cap_m = (cap_m & ~clr) | rise;
      if (wr && address == 2'd2) mask_m = writedata[7:0];
      p3 = p2; p2 = p1; p1 = in0;
      exp_irq = |(cap_m & mask_m);
      tick();
      n_tests++; if (rd0 !== exp_rd) begin n_fail++; $display("FAIL rand_rd: cycle %0d got %h exp %h", k, rd0, exp_rd); end
      n_tests++; if (irq0 !== exp_irq) begin n_fail++; $display("FAIL rand_irq: cycle %0d got %b exp %b", k, irq0, exp_irq); end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_irq();
    test_set_wins();
    test_filter();
    test_any_edge();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
